// File: rtl/vf_pattern_source_if.sv
// Frame-fetch link between usb_camera_top (master) and a pixel source (slave).
//   vf_sof  : start-of-frame pulse, master -> slave
//   vf_req  : pixel-advance request, master -> slave
//   vf_byte : current 8-bit pixel, slave -> master
interface vf_pattern_source_if;
    logic       vf_sof;
    logic       vf_req;
    logic [7:0] vf_byte;

    modport master (
        output vf_sof,
        output vf_req,
        input  vf_byte
    );

    modport slave (
        input  vf_sof,
        input  vf_req,
        output vf_byte
    );
endinterface

// File: rtl/vf_pattern_source.sv
// Synthetic MONO8 frame source for the usb_camera_top frame-fetch interface.
// Presents pixel(k) on vf_byte, where k counts vf_req pulses since the last vf_sof.
// Ports:
//   clk       : pixel/USB core clock
//   rstn      : asynchronous active-low reset
//   mode      : pattern select (0 gradient, 1 bars, 2 checker, 3 bouncing box),
//               sampled at vf_sof
//   vf        : slave side of the frame-fetch link (vf_sof, vf_req in; vf_byte out)
//   frame_cnt : frame counter, +1 at every vf_sof, wraps 255 -> 0
//   overrun   : sticky, a request arrived past the last pixel of the frame
module vf_pattern_source #(
    parameter int unsigned FRAME_W  = 252,
    parameter int unsigned FRAME_H  = 120,
    parameter int unsigned BOX_SIZE = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [1:0]          mode,
    vf_pattern_source_if.slave  vf,
    output logic [7:0]          frame_cnt,
    output logic                overrun
);

    localparam logic [13:0] X_LAST    = 14'(FRAME_W - 1);
    localparam logic [13:0] Y_LAST    = 14'(FRAME_H - 1);
    localparam logic [13:0] BOX_X_MAX = 14'(FRAME_W - BOX_SIZE);
    localparam logic [13:0] BOX_Y_MAX = 14'(FRAME_H - BOX_SIZE);
    localparam logic [14:0] BOX_LEN   = 15'(BOX_SIZE);

    logic [13:0] x_q, x_d;
    logic [13:0] y_q, y_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [13:0] box_x_q, box_x_d;
    logic [13:0] box_y_q, box_y_d;
    logic        dx_neg_q, dx_neg_d;   // 1: box moving toward x = 0
    logic        dy_neg_q, dy_neg_d;   // 1: box moving toward y = 0
    logic        overrun_q, overrun_d;
    logic [7:0]  vf_byte_q, vf_byte_d;
    logic        in_box;

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        mode_d      = mode_q;
        frame_cnt_d = frame_cnt_q;
        box_x_d     = box_x_q;
        box_y_d     = box_y_q;
        dx_neg_d    = dx_neg_q;
        dy_neg_d    = dy_neg_q;
        overrun_d   = overrun_q;

        if (vf.vf_sof) begin
            // vf_sof takes priority; a coincident vf_req is dropped.
            mode_d      = mode;
            frame_cnt_d = frame_cnt_q + 8'd1;
            box_x_d     = dx_neg_q ? box_x_q - 14'd1 : box_x_q + 14'd1;
            box_y_d     = dy_neg_q ? box_y_q - 14'd1 : box_y_q + 14'd1;
            if (box_x_d == BOX_X_MAX) begin
                dx_neg_d = 1'b1;
            end else if (box_x_d == 14'd0) begin
                dx_neg_d = 1'b0;
            end
            if (box_y_d == BOX_Y_MAX) begin
                dy_neg_d = 1'b1;
            end else if (box_y_d == 14'd0) begin
                dy_neg_d = 1'b0;
            end
            x_d       = 14'd0;
            y_d       = 14'd0;
            overrun_d = 1'b0;
        end else if (vf.vf_req) begin
            if (x_q == X_LAST) begin
                x_d = 14'd0;
                if (y_q == Y_LAST) begin
                    y_d       = 14'd0;
                    overrun_d = 1'b1;
                end else begin
                    y_d = y_q + 14'd1;
                end
            end else begin
                x_d = x_q + 14'd1;
            end
        end
    end

    // The pixel is computed from next-state values so vf_byte tracks k with
    // exactly one cycle of latency, including the new frame's settings at vf_sof.
    always_comb begin
        in_box = ({1'b0, x_d} >= {1'b0, box_x_d}) &&
                 ({1'b0, x_d} <  {1'b0, box_x_d} + BOX_LEN) &&
                 ({1'b0, y_d} >= {1'b0, box_y_d}) &&
                 ({1'b0, y_d} <  {1'b0, box_y_d} + BOX_LEN);

        vf_byte_d = 8'h00;
        unique case (mode_d)
            2'd0: vf_byte_d = x_d[7:0] + y_d[7:0] + frame_cnt_d;
            2'd1: vf_byte_d = {x_d[7:5], 5'b00000};
            2'd2: vf_byte_d = (x_d[4] ^ y_d[4]) ? 8'hFF : 8'h00;
            2'd3: vf_byte_d = in_box ? 8'hFF : 8'h40;
            default: vf_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q         <= 14'd0;
            y_q         <= 14'd0;
            mode_q      <= 2'd0;
            frame_cnt_q <= 8'd0;
            box_x_q     <= 14'd0;
            box_y_q     <= 14'd0;
            dx_neg_q    <= 1'b0;
            dy_neg_q    <= 1'b0;
            overrun_q   <= 1'b0;
            vf_byte_q   <= 8'd0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            box_x_q     <= box_x_d;
            box_y_q     <= box_y_d;
            dx_neg_q    <= dx_neg_d;
            dy_neg_q    <= dy_neg_d;
            overrun_q   <= overrun_d;
            vf_byte_q   <= vf_byte_d;
        end
    end

    assign vf.vf_byte = vf_byte_q;
    assign frame_cnt  = frame_cnt_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vf_pattern_source.sv
// Self-checking bench for vf_pattern_source. A behavioural model tracks the
// pixel index, frame count and latched mode; expected pixels are queued as each
// cycle of stimulus is driven and popped when the registered output appears.
module tb_vf_pattern_source;

    localparam int W = 252;
    localparam int H = 120;
    localparam int B = 16;

    logic       clk;
    logic       rstn;
    logic [1:0] mode;
    logic [7:0] frame_cnt;
    logic       overrun;

    vf_pattern_source_if vf ();

    vf_pattern_source #(
        .FRAME_W  (W),
        .FRAME_H  (H),
        .BOX_SIZE (B)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mode      (mode),
        .vf        (vf),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_px;

    // Model state
    int         m_k;
    int         m_sofs;
    logic [1:0] m_mode;
    logic       m_over;

    // Triangle-wave position after n steps bouncing between 0 and m.
    function automatic int tri_pos(input int n, input int m);
        int p;
        p = n % (2 * m);
        return (p <= m) ? p : 2 * m - p;
    endfunction

    function automatic logic [7:0] model_px();
        int x, y, bx, by;
        x  = m_k % W;
        y  = m_k / W;
        bx = tri_pos(m_sofs, W - B);
        by = tri_pos(m_sofs, H - B);
        case (m_mode)
            2'd0: return 8'((x + y + m_sofs) % 256);
            2'd1: return 8'(((x / 32) % 8) * 32);
            2'd2: return (((x / 16) % 2) != ((y / 16) % 2)) ? 8'hFF : 8'h00;
            default: return (x >= bx && x < bx + B && y >= by && y < by + B) ? 8'hFF : 8'h40;
        endcase
    endfunction

    function automatic void model_reset();
        m_k    = 0;
        m_sofs = 0;
        m_mode = 2'd0;
        m_over = 1'b0;
        sb.delete();
    endfunction

    // Drive one cycle of vf_sof/vf_req, update the model, queue the expected pixel.
    // Returns at posedge + 1.
    task automatic step(input logic sof, input logic req);
        vf.vf_sof = sof;
        vf.vf_req = req;
        if (sof) begin
            m_sofs = m_sofs + 1;
            m_mode = mode;
            m_k    = 0;
            m_over = 1'b0;
        end else if (req) begin
            m_k = m_k + 1;
            if (m_k == W * H) begin
                m_k    = 0;
                m_over = 1'b1;
            end
        end
        sb.push_back(model_px());
        @(posedge clk);
        #1;
        vf.vf_sof = 1'b0;
        vf.vf_req = 1'b0;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        #3;
        rstn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        vf.vf_sof = 1'b0;
        vf.vf_req = 1'b0;
        mode = 2'd0;
        model_reset();
        #1;
        total++;
        if (vf.vf_byte !== 8'h00) begin
            bad++; $display("FAIL reset_byte got=%h want=00", vf.vf_byte);
        end
        total++;
        if (frame_cnt !== 8'h00) begin
            bad++; $display("FAIL reset_frame_cnt got=%h want=00", frame_cnt);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL reset_overrun got=%b want=0", overrun);
        end
        #16;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_gradient();
        mode = 2'd0;
        step(1'b1, 1'b0);
        exp_px = sb.pop_front();
        total++;
        if (vf.vf_byte !== exp_px || vf.vf_byte !== 8'h01) begin
            bad++; $display("FAIL grad_sof got=%h want=%h", vf.vf_byte, exp_px);
        end
        total++;
        if (frame_cnt !== 8'd1) begin
            bad++; $display("FAIL grad_frame_cnt got=%0d want=1", frame_cnt);
        end
        for (int i = 1; i <= 252; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL grad_px k=%0d got=%h want=%h", m_k, vf.vf_byte, exp_px);
            end
            if (i == 3) begin
                total++;
                if (vf.vf_byte !== 8'h04) begin
                    bad++; $display("FAIL grad_k3 got=%h want=04", vf.vf_byte);
                end
            end
        end
        total++;
        if (vf.vf_byte !== 8'h02) begin
            bad++; $display("FAIL grad_row1 got=%h want=02", vf.vf_byte);
        end
    endtask

    task automatic test_bars();
        mode = 2'd1;
        step(1'b1, 1'b0);
        exp_px = sb.pop_front();
        total++;
        if (vf.vf_byte !== exp_px) begin
            bad++; $display("FAIL bars_sof got=%h want=%h", vf.vf_byte, exp_px);
        end
        for (int i = 0; i < 37; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL bars_px k=%0d got=%h want=%h", m_k, vf.vf_byte, exp_px);
            end
        end
        total++;
        if (vf.vf_byte !== 8'h20) begin
            bad++; $display("FAIL bars_k37 got=%h want=20", vf.vf_byte);
        end
    endtask

    task automatic test_checker();
        mode = 2'd2;
        step(1'b1, 1'b0);
        exp_px = sb.pop_front();
        for (int i = 1; i <= 16 * W + 16; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL chk_px k=%0d got=%h want=%h", m_k, vf.vf_byte, exp_px);
            end
            if (i == 16) begin
                total++;
                if (vf.vf_byte !== 8'hFF) begin
                    bad++; $display("FAIL chk_x16_y0 got=%h want=ff", vf.vf_byte);
                end
            end
        end
        total++;
        if (vf.vf_byte !== 8'h00) begin
            bad++; $display("FAIL chk_x16_y16 got=%h want=00", vf.vf_byte);
        end
    endtask

    task automatic test_simultaneous();
        mode = 2'd0;
        step(1'b1, 1'b0);
        exp_px = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
        end
        // sof + req together: sof wins, pixel(0) of the new frame
        step(1'b1, 1'b1);
        exp_px = sb.pop_front();
        total++;
        if (vf.vf_byte !== exp_px) begin
            bad++; $display("FAIL sim_sof_req got=%h want=%h", vf.vf_byte, exp_px);
        end
        // mode change mid-frame has no effect until the next sof
        for (int i = 0; i < 40; i++) begin
            if (i == 5) mode = 2'd1;
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL sim_mode_hold k=%0d got=%h want=%h", m_k, vf.vf_byte,
                                exp_px);
            end
        end
        step(1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
        end
        for (int i = 0; i < 41; i++) begin
            exp_px = sb.pop_front();
        end
        total++;
        if (vf.vf_byte !== exp_px || vf.vf_byte !== 8'h20) begin
            bad++; $display("FAIL sim_mode_new got=%h want=%h", vf.vf_byte, exp_px);
        end
    endtask

    task automatic test_box();
        apply_reset();
        mode = 2'd3;
        step(1'b1, 1'b0);
        exp_px = sb.pop_front();
        total++;
        if (vf.vf_byte !== 8'h40) begin
            bad++; $display("FAIL box_px0 got=%h want=40", vf.vf_byte);
        end
        for (int i = 0; i < 253; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL box_px k=%0d got=%h want=%h", m_k, vf.vf_byte, exp_px);
            end
        end
        total++;
        if (vf.vf_byte !== 8'hFF) begin
            bad++; $display("FAIL box_x1_y1 got=%h want=ff", vf.vf_byte);
        end
    endtask

    // Scan mode-3 frame `n_frame` up to pixel index `k_end`, checking every pixel.
    task automatic scan_frame(input int n_frame, input int k_end);
        while (m_sofs < n_frame) begin
            step(1'b1, 1'b0);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL bnc_px0 frame=%0d got=%h want=%h", m_sofs, vf.vf_byte,
                                exp_px);
            end
        end
        for (int i = 0; i < k_end; i++) begin
            step(1'b0, 1'b1);
            exp_px = sb.pop_front();
            total++;
            if (vf.vf_byte !== exp_px) begin
                bad++; $display("FAIL bnc_px frame=%0d k=%0d got=%h want=%h", m_sofs, m_k,
                                vf.vf_byte, exp_px);
            end
        end
    endtask

    task automatic test_bounce_overrun();
        apply_reset();
        mode = 2'd3;
        // frame 104: box at (104,104); stream the whole frame plus the wrap
        scan_frame(104, W * H - 1);
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_early got=%b want=0", overrun);
        end
        step(1'b0, 1'b1);
        exp_px = sb.pop_front();
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_set got=%b want=1", overrun);
        end
        total++;
        if (vf.vf_byte !== 8'h40 || vf.vf_byte !== exp_px) begin
            bad++; $display("FAIL ovr_wrap_px got=%h want=%h", vf.vf_byte, exp_px);
        end
        // frame 105: box_y has turned around to 103
        scan_frame(105, 103 * W + 105);
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL ovr_clear got=%b want=0", overrun);
        end
        total++;
        if (vf.vf_byte !== 8'hFF) begin
            bad++; $display("FAIL bnc_y103 got=%h want=ff", vf.vf_byte);
        end
        // frame 236: box_x = 236, box_y = 28
        scan_frame(236, 28 * W + 236);
        total++;
        if (vf.vf_byte !== 8'hFF) begin
            bad++; $display("FAIL bnc_x236 got=%h want=ff", vf.vf_byte);
        end
        // frame 237: box_x = 235, box_y = 29
        scan_frame(237, 29 * W + 235);
        total++;
        if (vf.vf_byte !== 8'hFF) begin
            bad++; $display("FAIL bnc_x235 got=%h want=ff", vf.vf_byte);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        mode = 2'd3;
        scan_frame(50, 300);
        total++;
        if (frame_cnt !== 8'd50) begin
            bad++; $display("FAIL rmid_pre_cnt got=%0d want=50", frame_cnt);
        end
        #2;
        rstn = 1'b0;
        #1;
        total++;
        if (vf.vf_byte !== 8'h00) begin
            bad++; $display("FAIL rmid_byte got=%h want=00", vf.vf_byte);
        end
        total++;
        if (frame_cnt !== 8'h00) begin
            bad++; $display("FAIL rmid_cnt got=%h want=00", frame_cnt);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++; $display("FAIL rmid_ovr got=%b want=0", overrun);
        end
        #2;
        rstn = 1'b1;
        model_reset();
        scan_frame(1, 253);
        total++;
        if (frame_cnt !== 8'd1) begin
            bad++; $display("FAIL rmid_post_cnt got=%0d want=1", frame_cnt);
        end
        total++;
        if (vf.vf_byte !== 8'hFF) begin
            bad++; $display("FAIL rmid_box11 got=%h want=ff", vf.vf_byte);
        end
    endtask

    initial begin
        test_reset();
        test_gradient();
        test_bars();
        test_checker();
        test_simultaneous();
        test_box();
        test_bounce_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vf_pattern_source.md
Name: vf_pattern_source

Overview:
- Synthetic video-frame source that drives the usb_camera_top frame-fetch interface (vf_sof / vf_req / vf_byte).
- Produces MONO 8-bit pixels for a FRAME_W x FRAME_H frame using one of four selectable test patterns.
- Sits directly upstream of usb_camera_top. It replaces the free-running byte counter in the FPGA top and serves as a bring-up and regression source before a real sensor path exists.

Parameters:
- FRAME_W, 252, frame width in pixels; even, 16..16383; must equal the usb_camera_top FRAME_W.
- FRAME_H, 120, frame height in pixels; even, 16..16383; must equal the usb_camera_top FRAME_H.
- BOX_SIZE, 16, side length of the bouncing box in pixels; must be smaller than both FRAME_W and FRAME_H.

Ports:
- clk  input  1  pixel/USB core clock (60 MHz in the camera design)
- rstn  input  1  asynchronous active-low reset
- mode  input  2  pattern select: 0 = gradient, 1 = vertical bars, 2 = checkerboard, 3 = bouncing box
- vf_sof  input  1  start-of-frame pulse from usb_camera_top
- vf_req  input  1  pixel-advance request from usb_camera_top
- vf_byte  output  8  current pixel value (registered)
- frame_cnt  output  8  frame counter; increments at every vf_sof and wraps 255 -> 0
- overrun  output  1  sticky flag: a request arrived past the last pixel of the frame

Behaviour:
- Core contract: vf_byte always equals pixel(k), where k is the number of vf_req pulses accepted since the last vf_sof. Registered output; one-cycle latency after the vf_sof or vf_req that changes k.
- Coordinates: x counts 0..FRAME_W-1, y counts 0..FRAME_H-1, raster order.
  - Each accepted vf_req moves to x+1.
  - At x = FRAME_W-1, x goes to 0 and y goes to y+1.
- Simultaneous vf_sof and vf_req: vf_sof wins and vf_req is ignored in that cycle.
- On vf_sof, all of the following take effect together and apply to the whole new frame, including pixel(0) presented on the next cycle:
  - mode is latched into mode_q;
  - frame_cnt increments;
  - the box position steps;
  - x = y = 0;
  - overrun clears.
- Changes to mode mid-frame are ignored until the next vf_sof.
- Pattern values (x, y taken modulo 256 where 8 bits are needed):
  - Mode 0: (x + y + frame_cnt) mod 256.
  - Mode 1: {x[7:5], 5'b00000}.
  - Mode 2: 8'hFF if x[4] XOR y[4], else 8'h00.
  - Mode 3: 8'hFF if box_x <= x < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE, else 8'h40.
- Box motion, evaluated at each vf_sof:
  - box_x += dx, box_y += dy (each step is +1 or -1).
  - If the new box_x equals FRAME_W-BOX_SIZE, dx becomes -1; if it equals 0, dx becomes +1. The same rule applies to y with FRAME_H-BOX_SIZE.
  - The box steps in every frame regardless of mode.
- End of frame: when vf_req is accepted at x = FRAME_W-1, y = FRAME_H-1, overrun is set and x, y wrap to 0, 0. Later requests keep producing pixels. overrun stays set until the next vf_sof or reset.
- Requests before the first vf_sof after reset are served normally, using the reset state.
- Reset values (asynchronous, rstn = 0):
  - vf_byte = 0, frame_cnt = 0, overrun = 0;
  - x = y = 0, mode_q = 0;
  - box_x = box_y = 0, dx = dy = +1.
- Reset mid-frame: all state returns immediately to the reset values. The first vf_sof after release starts frame_cnt = 1 with the box at (1,1).
- Width rules: x and y are 14 bits; box_x and box_y are 14 bits; all pattern arithmetic is 8-bit and truncating.

Test Plan:
- Reset, mode = 0, one vf_sof -> frame_cnt = 1, vf_byte = 0x01. After 3 vf_req -> 0x04. After 252 vf_req total -> (x=0, y=1) = 0x02.
- mode = 1, vf_sof, 37 vf_req -> vf_byte = 0x20. mode = 2: x=16, y=0 -> 0xFF; x=16, y=16 -> 0x00.
- mode = 3, first vf_sof after reset -> pixel(0) = 0x40; at k = 253 (x=1, y=1) -> 0xFF.
- Box bounce: after 236 vf_sof -> box_x = 236; 237th -> 235. After 104 vf_sof -> box_y = 104; 105th -> 103.
- Simultaneous events:
  - vf_sof and vf_req in the same cycle -> vf_byte = pixel(0);
  - mode changed mid-frame -> pattern unchanged until the next vf_sof;
  - 30240 vf_req -> overrun = 1 and vf_byte = pixel(0), cleared by the next vf_sof.
- Assert rstn low mid-frame (mode 3, frame_cnt = 50) -> all outputs are 0 in the same cycle. After release plus vf_sof -> frame_cnt = 1, box at (1,1).
